// File: rtl/booth_operand_queue.sv
// Operand staging queue in front of the Booth multiplier: buffers multiplicand/multiplier pairs.
// Latency: push-to-start 1 cycle on an empty queue with an idle multiplier; one job per (run time + 2) cycles.
// Backpressure: in_ready low while the queue is full, from the registered count only; launch waits on mult_ready.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    producer handshake; in_mcand/in_mplier carry the pair
//   mult_ready           multiplier idle indication
//   start                launch request (combinational, IDLE state only)
//   empty, count         occupancy of the queue
//   word1/word2          multiplicand/multiplier at the queue head
//   job_done             one-cycle pulse when the in-flight job completes
//   wdog_err             sticky watchdog error
//
// Optional feature: define BOOTH_OPQ_WDOG_EN to build a busy-cycle watchdog.
// Without it, wdog_err is constant 0 and the BUSY state waits indefinitely.

module booth_operand_queue #(
  parameter int L_WORD      = 4,
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [L_WORD-1:0]          in_mcand,
  input  logic [L_WORD-1:0]          in_mplier,
  input  logic                       mult_ready,
  output logic                       start,
  output logic                       empty,
  output logic [L_WORD-1:0]          word1,
  output logic [L_WORD-1:0]          word2,
  output logic                       job_done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       wdog_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [L_WORD-1:0] r_mem_mcand  [DEPTH];
  logic [L_WORD-1:0] r_mem_mplier [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_in_ready;
  logic w_start;
  logic w_job_done;
  logic w_wdog_hit;

  // Full-queue acceptance depends only on the registered count, so a pop in
  // the same cycle does not open a slot for a push.
  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = in_valid && w_in_ready;

  // Launch only from IDLE with something queued; a freshly pushed pair is
  // not visible in r_count until the next cycle.
  assign w_start    = (r_state == S_IDLE) && (r_count != '0) && mult_ready;
  assign w_pop      = w_start;
  assign w_job_done = (r_state == S_BUSY) && mult_ready;

  assign in_ready = w_in_ready;
  assign start    = w_start;
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign job_done = w_job_done;
  assign word1    = r_mem_mcand[r_rd_ptr];
  assign word2    = r_mem_mplier[r_rd_ptr];

  // Storage is cleared on reset so the head words read 0 afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_mcand[i]  <= '0;
        r_mem_mplier[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_mcand[r_wr_ptr]  <= in_mcand;
      r_mem_mplier[r_wr_ptr] <= in_mplier;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BOOTH_OPQ_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES+1);

  logic [WCW-1:0] r_wdog_cnt;
  logic           r_wdog_err;

  // The counter holds k-1 during the k-th BUSY cycle, so the limit is hit in
  // BUSY cycle WDOG_CYCLES and the error is visible right after it.
  assign w_wdog_hit = (r_state == S_BUSY) && !mult_ready &&
                      (r_wdog_cnt == WCW'(WDOG_CYCLES-1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_wdog_cnt <= '0;
      end else if ((r_state == S_BUSY) && !mult_ready) begin
        r_wdog_cnt <= r_wdog_cnt + WCW'(1);
      end
      if (w_wdog_hit) begin
        r_wdog_err <= 1'b1;
      end
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_hit = 1'b0;
  // The comparison keeps the limit parameter referenced; the result is always 0.
  assign wdog_err   = (WDOG_CYCLES < 0);
`endif

  // Reset abandons any in-flight job; returning to IDLE means no job_done for it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mult_ready || w_wdog_hit) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_operand_queue.sv
// Bench for booth_operand_queue: vector table plus hand sequences for timing corners.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Handshake stalls come from holding mult_ready low; the queue-full case is in the vector table.

module tb_booth_operand_queue;

  localparam int L_WORD = 4;
  localparam int DEPTH  = 4;
  localparam int NVEC   = 27;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_mcand;
  logic [3:0] in_mplier;
  logic       mult_ready;
  logic       start;
  logic       empty;
  logic [3:0] word1;
  logic [3:0] word2;
  logic       job_done;
  logic [2:0] count;
  logic       wdog_err;

  int n_checks;
  int n_errors;

  booth_operand_queue #(
    .L_WORD     (L_WORD),
    .DEPTH      (DEPTH),
    .WDOG_CYCLES(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mcand  (in_mcand),
    .in_mplier (in_mplier),
    .mult_ready(mult_ready),
    .start     (start),
    .empty     (empty),
    .word1     (word1),
    .word2     (word2),
    .job_done  (job_done),
    .count     (count),
    .wdog_err  (wdog_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       vld;
    logic [3:0] mc;
    logic [3:0] mp;
    logic       mr;
    logic       e_ir;
    logic       e_st;
    logic       e_em;
    logic [3:0] e_w1;
    logic [3:0] e_w2;
    logic       e_jd;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vec [NVEC];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] mc, input logic [3:0] mp, input logic mr);
    in_valid   = v;
    in_mcand   = mc;
    in_mplier  = mp;
    mult_ready = mr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    reset = 1'b1;

    // Columns: vld, mcand, mplier, mult_ready | in_ready, start, empty, word1, word2, job_done, count
    vec[0]  = '{1'b1, 4'd3,  4'd5,  1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 3'd0};
    vec[1]  = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  4'd5,  1'b0, 3'd1};
    vec[2]  = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 3'd0};
    vec[3]  = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0,  1'b1, 3'd0};
    vec[4]  = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 3'd0};
    vec[5]  = '{1'b1, 4'd1,  4'd2,  1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 3'd0};
    vec[6]  = '{1'b1, 4'd3,  4'd4,  1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  4'd2,  1'b0, 3'd1};
    vec[7]  = '{1'b1, 4'd5,  4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  4'd2,  1'b0, 3'd2};
    vec[8]  = '{1'b1, 4'd7,  4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  4'd2,  1'b0, 3'd3};
    vec[9]  = '{1'b1, 4'd9,  4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  4'd2,  1'b0, 3'd4};
    vec[10] = '{1'b1, 4'd9,  4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  4'd2,  1'b0, 3'd4};
    vec[11] = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd3,  4'd4,  1'b0, 3'd3};
    vec[12] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  4'd4,  1'b1, 3'd3};
    vec[13] = '{1'b1, 4'd11, 4'd12, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  4'd4,  1'b0, 3'd3};
    vec[14] = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  4'd6,  1'b0, 3'd3};
    vec[15] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd5,  4'd6,  1'b1, 3'd3};
    vec[16] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  4'd6,  1'b0, 3'd3};
    vec[17] = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd7,  4'd8,  1'b0, 3'd2};
    vec[18] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd7,  4'd8,  1'b1, 3'd2};
    vec[19] = '{1'b1, 4'd13, 4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7,  4'd8,  1'b0, 3'd2};
    vec[20] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 4'd12, 1'b1, 3'd2};
    vec[21] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd11, 4'd12, 1'b0, 3'd2};
    vec[22] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 4'd14, 1'b1, 3'd1};
    vec[23] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 4'd14, 1'b0, 3'd1};
    vec[24] = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd6,  1'b0, 3'd0};
    vec[25] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  4'd6,  1'b1, 3'd0};
    vec[26] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  4'd6,  1'b0, 3'd0};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst in_ready", in_ready, 1);
    chk("rst start",    start,    0);
    chk("rst empty",    empty,    1);
    chk("rst word1",    word1,    0);
    chk("rst word2",    word2,    0);
    chk("rst job_done", job_done, 0);
    chk("rst count",    count,    0);
    chk("rst wdog_err", wdog_err, 0);
    tick();

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].vld, vec[i].mc, vec[i].mp, vec[i].mr);
      @(negedge clock);
      chk($sformatf("vec%0d in_ready", i), in_ready, vec[i].e_ir);
      chk($sformatf("vec%0d start",    i), start,    vec[i].e_st);
      chk($sformatf("vec%0d empty",    i), empty,    vec[i].e_em);
      chk($sformatf("vec%0d word1",    i), word1,    vec[i].e_w1);
      chk($sformatf("vec%0d word2",    i), word2,    vec[i].e_w2);
      chk($sformatf("vec%0d job_done", i), job_done, vec[i].e_jd);
      chk($sformatf("vec%0d count",    i), count,    vec[i].e_cnt);
      tick();
    end

    // Late completion: mult_ready rises 5 cycles after launch
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    tick();
    drive(1'b1, 4'd4, 4'd5, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    @(negedge clock);
    chk("late start A", start, 1);
    chk("late word1 A", word1, 2);
    chk("late word2 A", word2, 3);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      @(negedge clock);
      chk($sformatf("late busy%0d job_done", k), job_done, 0);
      chk($sformatf("late busy%0d start", k),    start,    0);
      tick();
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    @(negedge clock);
    chk("late job_done", job_done, 1);
    chk("late start while done", start, 0);
    tick();
    @(negedge clock);
    chk("late next start", start, 1);
    chk("late next job_done", job_done, 0);
    chk("late word1 B", word1, 4);
    chk("late word2 B", word2, 5);
    tick();
    @(negedge clock);
    chk("late B job_done", job_done, 1);
    tick();
    @(negedge clock);
    chk("late no start when empty", start, 0);
    chk("late empty", empty, 1);
    tick();

    // Reset while BUSY with three pairs still queued
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'(k), 4'(k), 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    @(negedge clock);
    chk("mid start", start, 1);
    chk("mid word1", word1, 1);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clock);
    chk("mid busy count", count, 3);
    reset      = 1'b1;
    mult_ready = 1'b1;
    #1;
    chk("mid rst count",    count,    0);
    chk("mid rst empty",    empty,    1);
    chk("mid rst start",    start,    0);
    chk("mid rst job_done", job_done, 0);
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst word1",    word1,    0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk($sformatf("post rst%0d job_done", k), job_done, 0);
      chk($sformatf("post rst%0d start", k),    start,    0);
      tick();
    end

`ifdef BOOTH_OPQ_WDOG_EN
    // Watchdog with mult_ready held low after launch
    drive(1'b1, 4'd6, 4'd7, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    @(negedge clock);
    chk("wdog launch", start, 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      @(negedge clock);
      chk($sformatf("wdog busy%0d err", k),      wdog_err, 0);
      chk($sformatf("wdog busy%0d job_done", k), job_done, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'd0, 4'd0, (k == 2));
      @(negedge clock);
      chk($sformatf("wdog sticky%0d", k),     wdog_err, 1);
      chk($sformatf("wdog no done%0d", k),    job_done, 0);
      chk($sformatf("wdog no start%0d", k),   start,    0);
      tick();
    end
`else
    chk("wdog tied off", wdog_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_operand_queue.md
# booth_operand_queue

Operand staging queue sitting directly upstream of the Booth multiplier control unit and datapath. Accepts multiplicand/multiplier pairs over a valid/ready handshake, buffers up to DEPTH pairs, and launches one multiplication at a time. Launch uses the multiplier's `start`/`ready` protocol. Operands are held on `word1`/`word2` during the single cycle in which the multiplier loads them.

## Interface
- L_WORD, 4, operand width in bits (matches the multiplier's word length)
- DEPTH, 4, queue depth in operand pairs; power of two, ≥2
- WDOG_CYCLES, 64, watchdog limit in cycles (used only with the macro below)
- clock  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer presents a pair
- in_ready  output  1  queue can accept; high exactly when count < DEPTH
- in_mcand  input  L_WORD  multiplicand of the presented pair
- in_mplier  input  L_WORD  multiplier of the presented pair
- mult_ready  input  1  multiplier is idle (its `ready`)
- start  output  1  launch request to the multiplier
- empty  output  1  queue holds no pair; to the multiplier's `empty`
- word1  output  L_WORD  multiplicand at queue head
- word2  output  L_WORD  multiplier at queue head
- job_done  output  1  one-cycle pulse when the in-flight multiplication completes
- count  output  clog2(DEPTH+1)  pairs currently stored
- wdog_err  output  1  sticky watchdog error; constant 0 when the feature is compiled out

## Operation
- Circular buffer with wr_ptr and rd_ptr, each clog2(DEPTH) bits, both wrapping modulo DEPTH, plus a count register.
- Push occurs when `in_valid && in_ready`. The pair is written at wr_ptr, and wr_ptr increments.
- `in_ready` is derived from the registered count only. When full, no push is accepted, even in a cycle that also pops.
- `word1`/`word2` always reflect the entry at rd_ptr. `empty` = (count == 0).
- FSM with states S_IDLE and S_BUSY:
  - S_IDLE: `start` = (count != 0) && mult_ready, combinational. If `start` is high, pop at the clock edge (rd_ptr increments) and go to S_BUSY. Otherwise stay in S_IDLE.
  - S_BUSY: `start` = 0. When mult_ready = 1, assert `job_done` for that cycle and go to S_IDLE. Otherwise stay in S_BUSY.
- `start` is never asserted while `empty` = 1. The multiplier's empty/flush path is therefore never exercised by this block.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push into an empty queue: the pair becomes eligible for launch the following cycle, not the same cycle.
- Storage, pointers, count, and FSM are all cleared by reset, including mid-operation. An in-flight job is abandoned and no `job_done` is issued for it.

## Timing
- Reset values:
  - in_ready = 1, start = 0, empty = 1
  - word1 = word2 = 0, job_done = 0, count = 0, wdog_err = 0
  - FSM in S_IDLE
- Launch handshake:
  - Cycle N: `start` = 1 with head operands stable. The multiplier samples them at the rising edge ending cycle N.
  - Cycle N+1: mult_ready is expected to be 0, and the FSM is in S_BUSY.
- Completion: `job_done` is high in the first S_BUSY cycle with mult_ready = 1. The earliest next `start` is one cycle later.
- Push-to-start latency with an empty queue and an idle multiplier is 1 cycle: pushed at edge N, `start` asserted in cycle N+1.
- Throughput: one job per (multiplier run time + 2) cycles.

## Configuration
- Macro: `BOOTH_OPQ_WDOG_EN`.
- Defined:
  - A cycle counter clears on entry to S_BUSY and increments each S_BUSY cycle.
  - If it reaches WDOG_CYCLES with mult_ready still 0, `wdog_err` is set and stays set until reset.
  - The FSM returns to S_IDLE without pulsing `job_done`. A later mult_ready is needed before the next launch.
- Undefined: no counter logic is built, `wdog_err` is tied to 0, and S_BUSY waits indefinitely.

## Test plan
- Reset, then push (3,5) with mult_ready = 1 → start high the next cycle with word1 = 3, word2 = 5; count 1→0; S_BUSY entered.
- Push 4 pairs with mult_ready held 0 → count = 4, in_ready = 0; a 5th in_valid is ignored; pairs launch in push order once mult_ready = 1.
- Push while popping with count = 2 → count stays 2, and pointers wrap correctly after DEPTH+1 total pushes.
- Raise mult_ready 5 cycles after launch → job_done pulses exactly once; the next start appears one cycle later, only if count > 0.
- Assert reset while in S_BUSY with count = 3 → count = 0, empty = 1, start = 0, and no job_done.
- With `BOOTH_OPQ_WDOG_EN` and WDOG_CYCLES = 8, hold mult_ready at 0 after launch → wdog_err rises after 8 S_BUSY cycles and stays high; no job_done.
